// File: rtl/sync_evt_capture.sv
// Slow-domain event capture: resync, rising-edge pulse, pending flag with ack,
// wrapping counter with sticky overflow, maskable interrupt. Optional glitch filter: SYNC_EVT_FILTER_EN.
module sync_evt_capture #(
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 3
) (
    input  logic                 slow_clk,
    input  logic                 pad_cpu_rst_b,
    input  logic                 evt_in,
    input  logic                 int_en,
    input  logic                 evt_ack,
    input  logic                 cnt_clr,
    output logic                 evt_pulse,
    output logic                 evt_pend,
    output logic [CNT_WIDTH-1:0] evt_cnt,
    output logic                 evt_ovf,
    output logic                 evt_int
);

    localparam bit PARAMS_OK = (SYNC_STAGES >= 2) && (SYNC_STAGES <= 4) &&
                               (FILT_CYCLES >= 2) && (FILT_CYCLES <= 15) &&
                               (CNT_WIDTH >= 1);

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("sync_evt_capture: parameter out of legal range");
        end
    endgenerate

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lvl_s;
    logic                   lvl_f;
    logic                   lvl_d_q;
    logic                   rise;
    logic                   pulse_q;
    logic [0:0]             state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;

    // Resynchroniser: bit 0 is the metastability-exposed flop.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], evt_in};
    end

    assign lvl_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge slow_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef SYNC_EVT_FILTER_EN
    localparam logic [3:0] FILT_LAST = 4'(FILT_CYCLES - 1);

    logic       filt_q, filt_d;
    logic [3:0] run_q, run_d;

    // Run length of consecutive samples disagreeing with the filtered level.
    always_comb begin
        filt_d = filt_q;
        run_d  = run_q;
        if (lvl_s == filt_q) begin
            run_d = '0;
        end else if (run_q == FILT_LAST) begin
            filt_d = lvl_s;
            run_d  = '0;
        end else begin
            run_d = run_q + 4'd1;
        end
    end

    always_ff @(posedge slow_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            filt_q <= 1'b0;
            run_q  <= '0;
        end else begin
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    assign lvl_f = filt_q;
`else
    assign lvl_f = lvl_s;
`endif

    assign rise = lvl_f & ~lvl_d_q;

    // A coincident rise keeps the flag set so that event is not lost.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (evt_ack && !rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear wins over a coincident rise; that event is not counted.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (cnt_clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (rise) begin
            cnt_d = cnt_q + CNT_ONE;
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge slow_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            lvl_d_q <= 1'b0;
            pulse_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            lvl_d_q <= lvl_f;
            pulse_q <= rise;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt_pulse = pulse_q;
    assign evt_pend  = (state_q == ST_PEND);
    assign evt_cnt   = cnt_q;
    assign evt_ovf   = ovf_q;
    assign evt_int   = evt_pend & int_en;

endmodule

// File: tb/tb_sync_evt_capture.sv
// Directed self-checking bench for sync_evt_capture (CNT_WIDTH=4 to reach the wrap quickly).
module tb_sync_evt_capture;

    localparam int unsigned CW = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned FC = 3;
`ifdef SYNC_EVT_FILTER_EN
    localparam int unsigned LAT  = SS + FC;
    localparam int unsigned HOLD = FC + 2;
    localparam int unsigned GAP  = FC + 4;
`else
    localparam int unsigned LAT  = SS;
    localparam int unsigned HOLD = 2;
    localparam int unsigned GAP  = 4;
`endif

    logic          slow_clk;
    logic          pad_cpu_rst_b;
    logic          evt_in;
    logic          int_en;
    logic          evt_ack;
    logic          cnt_clr;
    logic          evt_pulse;
    logic          evt_pend;
    logic [CW-1:0] evt_cnt;
    logic          evt_ovf;
    logic          evt_int;

    int checks = 0;
    int errors = 0;

    sync_evt_capture #(
        .CNT_WIDTH  (CW),
        .SYNC_STAGES(SS),
        .FILT_CYCLES(FC)
    ) dut (
        .slow_clk     (slow_clk),
        .pad_cpu_rst_b(pad_cpu_rst_b),
        .evt_in       (evt_in),
        .int_en       (int_en),
        .evt_ack      (evt_ack),
        .cnt_clr      (cnt_clr),
        .evt_pulse    (evt_pulse),
        .evt_pend     (evt_pend),
        .evt_cnt      (evt_cnt),
        .evt_ovf      (evt_ovf),
        .evt_int      (evt_int)
    );

    initial slow_clk = 1'b0;
    always #5 slow_clk = ~slow_clk;

    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic one_event();
        evt_in = 1'b1;
        repeat (HOLD) tick();
        evt_in = 1'b0;
        repeat (GAP) tick();
    endtask

    initial begin
        pad_cpu_rst_b = 1'b0;
        evt_in        = 1'b0;
        int_en        = 1'b0;
        evt_ack       = 1'b0;
        cnt_clr       = 1'b0;
        repeat (3) tick();
        chk("rst_pulse", 32'(evt_pulse), 32'd0);
        chk("rst_pend",  32'(evt_pend),  32'd0);
        chk("rst_cnt",   32'(evt_cnt),   32'd0);
        chk("rst_ovf",   32'(evt_ovf),   32'd0);
        chk("rst_int",   32'(evt_int),   32'd0);
        pad_cpu_rst_b = 1'b1;
        tick();

        // First event: single pulse at the (LAT+1)th edge, pend and count follow.
        evt_in = 1'b1;
        repeat (LAT) tick();
        chk("t1_pulse_early", 32'(evt_pulse), 32'd0);
        chk("t1_pend_early",  32'(evt_pend),  32'd0);
        tick();
        chk("t1_pulse", 32'(evt_pulse), 32'd1);
        chk("t1_pend",  32'(evt_pend),  32'd1);
        chk("t1_cnt",   32'(evt_cnt),   32'd1);
        chk("t1_int_masked", 32'(evt_int), 32'd0);
        tick();
        chk("t1_pulse_once", 32'(evt_pulse), 32'd0);
        int_en = 1'b1;
        #1;
        chk("t1_int_en", 32'(evt_int), 32'd1);
        tick();
        evt_in = 1'b0;
        repeat (GAP) tick();
        chk("t1_fall_pulse", 32'(evt_pulse), 32'd0);
        chk("t1_fall_cnt",   32'(evt_cnt),   32'd1);
        chk("t1_fall_pend",  32'(evt_pend),  32'd1);

        // Ack coincident with a new rise keeps pending.
        evt_in = 1'b1;
        repeat (LAT) tick();
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        chk("t2_pulse", 32'(evt_pulse), 32'd1);
        chk("t2_pend",  32'(evt_pend),  32'd1);
        chk("t2_cnt",   32'(evt_cnt),   32'd2);
        tick();
        evt_in = 1'b0;
        repeat (GAP) tick();
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        chk("t2_ack_pend", 32'(evt_pend), 32'd0);
        chk("t2_ack_int",  32'(evt_int),  32'd0);

        // Plain clear, then wrap through 15 -> 0 with sticky overflow.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("t3_clr_cnt", 32'(evt_cnt), 32'd0);
        chk("t3_clr_ovf", 32'(evt_ovf), 32'd0);
        repeat (15) one_event();
        chk("t3_cnt15", 32'(evt_cnt), 32'd15);
        chk("t3_ovf15", 32'(evt_ovf), 32'd0);
        one_event();
        chk("t3_wrap_cnt", 32'(evt_cnt), 32'd0);
        chk("t3_wrap_ovf", 32'(evt_ovf), 32'd1);
        one_event();
        chk("t3_cnt17", 32'(evt_cnt), 32'd1);
        chk("t3_ovf_sticky", 32'(evt_ovf), 32'd1);
        repeat (4) one_event();
        chk("t4_cnt5", 32'(evt_cnt), 32'd5);
        chk("t4_ovf5", 32'(evt_ovf), 32'd1);
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        chk("t4_pend_cleared", 32'(evt_pend), 32'd0);

        // Clear coincident with a rise: not counted, but pulse and pending still happen.
        evt_in = 1'b1;
        repeat (LAT) tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("t4_clr_cnt",   32'(evt_cnt),   32'd0);
        chk("t4_clr_ovf",   32'(evt_ovf),   32'd0);
        chk("t4_clr_pulse", 32'(evt_pulse), 32'd1);
        chk("t4_clr_pend",  32'(evt_pend),  32'd1);

        // Reset mid-PEND with the level still high.
        repeat (2) tick();
        pad_cpu_rst_b = 1'b0;
        #1;
        chk("t5_rst_pend", 32'(evt_pend), 32'd0);
        chk("t5_rst_int",  32'(evt_int),  32'd0);
        chk("t5_rst_cnt",  32'(evt_cnt),  32'd0);
        tick();
        chk("t5_rst_pulse", 32'(evt_pulse), 32'd0);
        chk("t5_rst_pend2", 32'(evt_pend),  32'd0);
        pad_cpu_rst_b = 1'b1;
        repeat (LAT) tick();
        chk("t5_pulse_early", 32'(evt_pulse), 32'd0);
        tick();
        chk("t5_pulse", 32'(evt_pulse), 32'd1);
        chk("t5_pend",  32'(evt_pend),  32'd1);
        chk("t5_cnt",   32'(evt_cnt),   32'd1);
        chk("t5_int",   32'(evt_int),   32'd1);
        tick();
        chk("t5_pulse_once", 32'(evt_pulse), 32'd0);
        evt_in = 1'b0;
        repeat (GAP) tick();

`ifdef SYNC_EVT_FILTER_EN
        begin
            int seen;
            int first;
            seen = 0;
            evt_in = 1'b1;
            repeat (2) tick();
            evt_in = 1'b0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (evt_pulse) seen++;
            end
            chk("t6_short_dropped", 32'(seen), 32'd0);
            seen  = 0;
            first = -1;
            evt_in = 1'b1;
            for (int i = 1; i <= 16; i++) begin
                tick();
                if (i == 4) evt_in = 1'b0;
                if (evt_pulse) begin
                    seen++;
                    if (first < 0) first = i;
                end
            end
            chk("t6_long_count", 32'(seen),  32'd1);
            chk("t6_long_lat",   32'(first), 32'(SS + FC + 1));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
